aemb_intc: RTL
==============

Name: aemb_intc

Overview:
- Wishbone-slave interrupt controller sitting directly upstream of the system control unit.
- Collects up to 32 asynchronous peripheral interrupt lines, synchronises them, latches pending edges and masks them with per-source and master enables.
- Drives the single registered sys_int_o that feeds the core's sys_int_i.
- Firmware identifies and acknowledges sources over the data bus.

Parameters:
IRQN, 8, number of interrupt sources (1..32)
EDGE, 32'hFFFFFFFF, per-source mode mask; bit i=1 rising-edge sticky, 0 level; only bits [IRQN-1:0] used

Ports:
gclk  in  1  system clock
grst  in  1  reset; synchronous, active-high
irq_i  in  IRQN  asynchronous interrupt requests
wb_stb_i  in  1  bus strobe (cycle qualifier folded in)
wb_we_i  in  1  write enable
wb_adr_i  in  2  word address [3:2]
wb_dat_i  in  32  write data
wb_dat_o  out  32  read data, valid with wb_ack_o
wb_ack_o  out  1  transfer acknowledge
sys_int_o  out  1  interrupt request to core (to sys_int_i)

Behaviour:
- Reset (grst high at posedge gclk): all registers and outputs clear to 0; wb_ack_o=0, wb_dat_o=0, sys_int_o=0. Reset mid-transfer drops any ack.
- Synchroniser per source: rS0<=irq_i, rS1<=rS0, rP<=rS1. edge = rS1 & ~rP.
- ISR (pending, addr 0):
  - Edge bit: set when edge; cleared by a write of 1 to that bit. Simultaneous set and clear: set wins.
  - Level bit: loads rS1 every cycle; writes ignored.
  - Bits >= IRQN read 0.
- IER (addr 1): read/write; bits >= IRQN read 0 and are not stored.
- IVR (addr 2, read-only):
  - Index of the lowest-numbered bit of ISR&IER, zero-extended.
  - 32'hFFFFFFFF when no bit is set.
  - MER does not affect IVR. Writes ignored.
- MER (addr 3): bit0 master enable, read/write; other bits read 0.
- Output: sys_int_o <= MER[0] & |(ISR & IER), registered.
- Latency: irq_i first sampled high at posedge k gives ISR bit set at k+2 and sys_int_o=1 at k+3 (IER and MER already set).
- IER/MER write affects sys_int_o one cycle after the write edge.
- Bus handshake:
  - wb_ack_o <= wb_stb_i & ~wb_ack_o: single-cycle pulse, one wait state, no back-to-back acks.
  - Write takes effect on the same edge ack is registered high.
  - wb_dat_o is registered on that edge from the addressed register (pre-write value); it is 0 when no ack is issued.
- Held stb: ack toggles 1,0,1... Each ack is a separate transfer.

Optional Feature:
AEMB_INTC_AUTOACK_EN
- Defined: an acknowledged read of IVR, with a valid index n on an edge-mode source, clears ISR[n] on the same edge. A coincident new edge on n wins.
- Not defined: IVR reads have no side effects. Firmware must clear ISR by writing 1.

Test Plan:
- Reset, then read all four regs -> ISR=0, IER=0, IVR=32'hFFFFFFFF, MER=0, sys_int_o=0.
- IER=8'h04, MER=1; pulse irq_i[2] high for 1 cycle at posedge k -> ISR=32'h4 at k+2, sys_int_o=1 at k+3, IVR=2. Write ISR=32'h4 -> ISR=0, sys_int_o=0 next cycle.
- EDGE=8'hFE, IRQN=8:
  - Hold irq_i[0]=1 -> ISR[0]=1 and stays 1 after writing 1.
  - Drop irq_i[0] -> ISR[0]=0 two cycles later.
- IER=8'hFF, MER=1; raise irq_i[5] and irq_i[3] together -> IVR=3. Clear bit 3 -> IVR=5. Set MER=0 -> sys_int_o=0 while ISR keeps 32'h20.
- Same-edge W1C of ISR[1] while a new rising edge on irq_i[1] reaches edge-detect -> ISR[1]=1.
- Hold wb_stb_i high for 4 cycles with reads -> wb_ack_o pattern 0,1,0,1. With AEMB_INTC_AUTOACK_EN, an IVR read returning 4 clears ISR[4]. Without it, ISR[4] remains 1.

Source files
------------

// File: rtl/aemb_intc.sv
// aemb_intc: Wishbone interrupt controller feeding the core's sys_int_i.
// Optional build macro: AEMB_INTC_AUTOACK_EN (IVR read clears its edge source).
module aemb_intc #(
  parameter int          IRQN = 8,
  parameter logic [31:0] EDGE = 32'hFFFFFFFF
) (
  input  logic            gclk,
  input  logic            grst,
  input  logic [IRQN-1:0] irq_i,
  input  logic            wb_stb_i,
  input  logic            wb_we_i,
  input  logic [1:0]      wb_adr_i,
  input  logic [31:0]     wb_dat_i,
  output logic [31:0]     wb_dat_o,
  output logic            wb_ack_o,
  output logic            sys_int_o
);

  logic [IRQN-1:0] rS0, rS1, rP;
  logic [IRQN-1:0] rIsr, rIer;
  logic            rMer;
  logic            rAck;
  logic [31:0]     rDat;
  logic            rInt;

  logic [IRQN-1:0] rise, pend;
  logic [IRQN-1:0] wrClr, autoClr, isrNxt;
  logic            wbAcc, wbWr;
  logic            ivrVld;
  logic [4:0]      ivrIdx;
  logic [31:0]     ivr, rdMux;
  logic            unusedDat;

  assign unusedDat = ^wb_dat_i;

  assign rise  = rS1 & ~rP;
  assign pend  = rIsr & rIer;
  assign wbAcc = wb_stb_i & ~rAck;
  assign wbWr  = wbAcc & wb_we_i;
  assign wrClr = (wbWr && wb_adr_i == 2'd0)
               ? wb_dat_i[IRQN-1:0] : '0;

  // lowest-numbered pending and enabled source
  always_comb begin
    ivrVld = 1'b0;
    ivrIdx = '0;
    for (int i = IRQN-1; i >= 0; i--) begin
      if (pend[i]) begin
        ivrVld = 1'b1;
        ivrIdx = 5'(i);
      end
    end
  end

  assign ivr = ivrVld ? {27'd0, ivrIdx} : 32'hFFFFFFFF;

`ifdef AEMB_INTC_AUTOACK_EN
  always_comb begin
    autoClr = '0;
    for (int i = 0; i < IRQN; i++) begin
      autoClr[i] = wbAcc & ~wb_we_i
                 & (wb_adr_i == 2'd2)
                 & ivrVld & (ivrIdx == 5'(i));
    end
  end
`else
  assign autoClr = '0;
`endif

  // edge bits are sticky with set winning over clear; level bits track rS1
  always_comb begin
    isrNxt = rIsr;
    for (int i = 0; i < IRQN; i++) begin
      if (EDGE[i])
        isrNxt[i] = rise[i]
                  | (rIsr[i] & ~(wrClr[i] | autoClr[i]));
      else
        isrNxt[i] = rS1[i];
    end
  end

  always_comb begin
    rdMux = '0;
    case (wb_adr_i)
      2'd0: rdMux = 32'(rIsr);
      2'd1: rdMux = 32'(rIer);
      2'd2: rdMux = ivr;
      2'd3: rdMux = {31'd0, rMer};
      default: rdMux = '0;
    endcase
  end

  always_ff @(posedge gclk) begin
    if (grst) begin
      rS0  <= '0;
      rS1  <= '0;
      rP   <= '0;
      rIsr <= '0;
      rIer <= '0;
      rMer <= 1'b0;
      rAck <= 1'b0;
      rDat <= '0;
      rInt <= 1'b0;
    end else begin
      rS0  <= irq_i;
      rS1  <= rS0;
      rP   <= rS1;
      rIsr <= isrNxt;
      rAck <= wbAcc;
      rDat <= wbAcc ? rdMux : 32'd0;
      rInt <= rMer & |pend;
      if (wbWr && wb_adr_i == 2'd1)
        rIer <= wb_dat_i[IRQN-1:0];
      if (wbWr && wb_adr_i == 2'd3)
        rMer <= wb_dat_i[0];
    end
  end

  assign wb_ack_o  = rAck;
  assign wb_dat_o  = rDat;
  assign sys_int_o = rInt;

endmodule
